// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction/format/tag in, extended immediate/tag out.
// Carries out_err when IMM_GEN_ERR_EN is defined.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_src;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
`ifdef IMM_GEN_ERR_EN
    logic             out_err;

    modport master (
        output in_valid, in_instr, in_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );
    modport slave (
        input  in_valid, in_instr, in_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
`else
    modport master (
        output in_valid, in_instr, in_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag
    );
    modport slave (
        input  in_valid, in_instr, in_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag
    );
`endif
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a head/skid two-entry buffer, flush and tag sideband.
// Optional IMM_GEN_ERR_EN adds a per-entry out_err flag for reserved format codes.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input logic           clk,
    input logic           reset,
    input logic           flush,
    imm_gen_pipe_if.slave bus
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} count_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
`ifdef IMM_GEN_ERR_EN
        logic             err;
`endif
    } entry_t;

    count_e count_q, count_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t new_entry;
    logic   in_ready_q;
    logic   push, pop, out_valid;
    logic   s;
    logic   src_err;
    logic   [31:0] imm32;
    logic   unused_opcode;

    assign s             = bus.in_instr[31];
    assign unused_opcode = ^bus.in_instr[6:0];

    always_comb begin
        imm32   = '0;
        src_err = 1'b0;
        case (bus.in_src)
            3'b000:  imm32 = {{20{s}}, bus.in_instr[31:20]};
            3'b001:  imm32 = {{20{s}}, bus.in_instr[31:25], bus.in_instr[11:7]};
            3'b010:  imm32 = {{19{s}}, bus.in_instr[31], bus.in_instr[7],
                              bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
            3'b011:  imm32 = {{11{s}}, bus.in_instr[31], bus.in_instr[19:12],
                              bus.in_instr[20], bus.in_instr[30:21], 1'b0};
            3'b100:  imm32 = {bus.in_instr[31:12], 12'b0};
            3'b101:  imm32 = {27'b0, bus.in_instr[19:15]};
            default: begin
                imm32   = '0;
                src_err = 1'b1;
            end
        endcase
    end

    // imm32[31] already holds the correct fill bit (0 for Z and reserved codes).
    always_comb begin
        new_entry     = '0;
        new_entry.imm = XLEN'(signed'(imm32));
        new_entry.tag = bus.in_tag;
`ifdef IMM_GEN_ERR_EN
        new_entry.err = src_err;
`endif
    end

`ifndef IMM_GEN_ERR_EN
    logic unused_src_err;
    assign unused_src_err = src_err;
`endif

    assign out_valid = (count_q != StEmpty);
    assign push      = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush wins over pop and discards a concurrent push; stale data is left in place.
            count_d = StEmpty;
        end else begin
            case (count_q)
                StEmpty: begin
                    if (push) begin
                        head_d  = new_entry;
                        count_d = StOne;
                    end
                end
                StOne: begin
                    if (push && !pop) begin
                        skid_d  = new_entry;
                        count_d = StTwo;
                    end else if (push && pop) begin
                        head_d  = new_entry;
                    end else if (pop) begin
                        count_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        head_d  = skid_q;
                        count_d = StOne;
                    end
                end
                default: count_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= StEmpty;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= (count_d != StTwo);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_imm   = head_q.imm;
    assign bus.out_tag   = head_q.tag;
`ifdef IMM_GEN_ERR_EN
    assign bus.out_err   = head_q.err;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: formats at XLEN 32/64, backpressure, streaming, flush, reset.
// Exercises out_err as well when IMM_GEN_ERR_EN is defined.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (b32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (b64)
    );

    localparam int NSW = 7;
    localparam logic [31:0] SW_INSTR [NSW] = '{32'h0000_0F80, 32'h8000_0000, 32'h8000_0000,
                                               32'h1234_5000, 32'h8000_0000, 32'h800F_8000,
                                               32'hFFFF_FFFF};
    localparam logic [2:0]  SW_SRC   [NSW] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6};
    localparam logic [31:0] SW_EXP32 [NSW] = '{32'h0000_001F, 32'hFFFF_F000, 32'hFFF0_0000,
                                               32'h1234_5000, 32'h8000_0000, 32'h0000_001F,
                                               32'h0000_0000};
    localparam logic [63:0] SW_EXP64 [NSW] = '{64'h0000_0000_0000_001F, 64'hFFFF_FFFF_FFFF_F000,
                                               64'hFFFF_FFFF_FFF0_0000, 64'h0000_0000_1234_5000,
                                               64'hFFFF_FFFF_8000_0000, 64'h0000_0000_0000_001F,
                                               64'h0000_0000_0000_0000};

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // I-format push whose immediate equals the tag, so order is visible on both fields.
    task automatic push_i(input logic [4:0] tag);
        b32.in_valid = 1'b1;
        b32.in_instr = {7'b0, tag, 20'h00013};
        b32.in_src   = 3'd0;
        b32.in_tag   = tag;
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        b32.in_valid  = 1'b0;
        b32.in_instr  = '0;
        b32.in_src    = '0;
        b32.in_tag    = '0;
        b32.out_ready = 1'b1;
        b64.in_valid  = 1'b0;
        b64.in_instr  = '0;
        b64.in_src    = '0;
        b64.in_tag    = '0;
        b64.out_ready = 1'b1;

        #2;
        check("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check("rst_in_ready", 64'(b32.in_ready), 64'd1);
        check("rst_out_imm", 64'(b32.out_imm), 64'd0);
        check("rst_out_tag", 64'(b32.out_tag), 64'd0);
        #10;
        reset = 1'b0;

        // I format, both widths
        b32.in_valid = 1'b1; b32.in_instr = 32'hFFF0_0093; b32.in_src = 3'd0; b32.in_tag = 5'd3;
        b64.in_valid = 1'b1; b64.in_instr = 32'hFFF0_0093; b64.in_src = 3'd0; b64.in_tag = 5'd3;
        tick();
        check("i_valid", 64'(b32.out_valid), 64'd1);
        check("i_imm32", 64'(b32.out_imm), 64'hFFFF_FFFF);
        check("i_tag", 64'(b32.out_tag), 64'd3);
        check("i_imm64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef IMM_GEN_ERR_EN
        check("i_err", 64'(b32.out_err), 64'd0);
`endif

        // Format sweep streamed back-to-back
        for (int i = 0; i < NSW; i++) begin
            b32.in_instr = SW_INSTR[i]; b32.in_src = SW_SRC[i]; b32.in_tag = 5'(i + 10);
            b64.in_instr = SW_INSTR[i]; b64.in_src = SW_SRC[i]; b64.in_tag = 5'(i + 10);
            tick();
            check($sformatf("sw%0d_imm32", i), 64'(b32.out_imm), 64'(SW_EXP32[i]));
            check($sformatf("sw%0d_imm64", i), b64.out_imm, SW_EXP64[i]);
            check($sformatf("sw%0d_tag", i), 64'(b32.out_tag), 64'(i + 10));
`ifdef IMM_GEN_ERR_EN
            check($sformatf("sw%0d_err", i), 64'(b32.out_err), (SW_SRC[i] >= 3'd6) ? 64'd1 : 64'd0);
`endif
        end
        b32.in_valid = 1'b0;
        b64.in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(b32.out_valid), 64'd0);
        check("drain_tag_hold", 64'(b32.out_tag), 64'd16);

        // Backpressure: 1,2 accepted, 3 held until space frees
        b32.out_ready = 1'b0;
        push_i(5'd1);
        tick();
        check("bp1_tag", 64'(b32.out_tag), 64'd1);
        check("bp1_rdy", 64'(b32.in_ready), 64'd1);
        push_i(5'd2);
        tick();
        check("bp2_rdy", 64'(b32.in_ready), 64'd0);
        check("bp2_tag", 64'(b32.out_tag), 64'd1);
        push_i(5'd3);
        tick();
        check("bp3_rdy", 64'(b32.in_ready), 64'd0);
        check("bp3_tag_stable", 64'(b32.out_tag), 64'd1);
        check("bp3_imm_stable", 64'(b32.out_imm), 64'd1);
        b32.out_ready = 1'b1;
        tick();
        check("bp_out2_tag", 64'(b32.out_tag), 64'd2);
        check("bp_out2_imm", 64'(b32.out_imm), 64'd2);
        check("bp_out2_rdy", 64'(b32.in_ready), 64'd1);
        tick();
        check("bp_out3_tag", 64'(b32.out_tag), 64'd3);
        check("bp_out3_valid", 64'(b32.out_valid), 64'd1);
        b32.in_valid = 1'b0;
        tick();
        check("bp_empty", 64'(b32.out_valid), 64'd0);

        // Continuous stream, push and pop together in ONE
        for (int i = 0; i < 8; i++) begin
            push_i(5'(20 + i));
            tick();
            check($sformatf("st%0d_valid", i), 64'(b32.out_valid), 64'd1);
            check($sformatf("st%0d_tag", i), 64'(b32.out_tag), 64'(20 + i));
            check($sformatf("st%0d_rdy", i), 64'(b32.in_ready), 64'd1);
        end
        b32.in_valid = 1'b0;
        tick();
        check("st_empty", 64'(b32.out_valid), 64'd0);

        // Flush in ONE with a concurrent push
        b32.out_ready = 1'b0;
        push_i(5'd4);
        tick();
        push_i(5'd5);
        flush = 1'b1;
        tick();
        check("fl1_valid", 64'(b32.out_valid), 64'd0);
        check("fl1_rdy", 64'(b32.in_ready), 64'd1);
        flush = 1'b0;
        b32.in_valid = 1'b0;
        b32.out_ready = 1'b1;
        tick();
        check("fl1_no_ghost", 64'(b32.out_valid), 64'd0);

        // Flush in TWO with a push attempt and pop
        b32.out_ready = 1'b0;
        push_i(5'd1);
        tick();
        push_i(5'd2);
        tick();
        check("fl2_full", 64'(b32.in_ready), 64'd0);
        push_i(5'd9);
        b32.out_ready = 1'b1;
        flush = 1'b1;
        tick();
        check("fl2_valid", 64'(b32.out_valid), 64'd0);
        check("fl2_rdy", 64'(b32.in_ready), 64'd1);
        flush = 1'b0;
        b32.in_valid = 1'b0;
        tick();
        check("fl2_no_ghost", 64'(b32.out_valid), 64'd0);
        push_i(5'd7);
        tick();
        check("fl2_next_tag", 64'(b32.out_tag), 64'd7);
        b32.in_valid = 1'b0;
        tick();
        check("fl2_next_empty", 64'(b32.out_valid), 64'd0);

        // Asynchronous reset with count=TWO
        b32.out_ready = 1'b0;
        push_i(5'd1);
        tick();
        push_i(5'd2);
        tick();
        b32.in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("ar_valid", 64'(b32.out_valid), 64'd0);
        check("ar_rdy", 64'(b32.in_ready), 64'd1);
        check("ar_imm", 64'(b32.out_imm), 64'd0);
        check("ar_tag", 64'(b32.out_tag), 64'd0);
        tick();
        reset = 1'b0;
        b32.out_ready = 1'b1;
        push_i(5'd11);
        tick();
        check("ar_first_valid", 64'(b32.out_valid), 64'd1);
        check("ar_first_tag", 64'(b32.out_tag), 64'd11);
`ifdef IMM_GEN_ERR_EN
        b32.in_instr = 32'hFFFF_FFFF; b32.in_src = 3'd7; b32.in_tag = 5'd12;
        tick();
        check("err_flag", 64'(b32.out_err), 64'd1);
        check("err_imm", 64'(b32.out_imm), 64'd0);
        check("err_tag", 64'(b32.out_tag), 64'd12);
`endif
        b32.in_valid = 1'b0;
        tick();
        check("end_empty", 64'(b32.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
